// File: rtl/usr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : usr_sequencer_if
// Brief  : Command, response and USR-control bundle for usr_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface usr_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic [WIDTH-1:0] cmd_data;

    logic [1:0]       usr_mode;
    logic [WIDTH-1:0] usr_pdata;
    logic             usr_sin;
    logic [WIDTH-1:0] usr_q;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data, rsp_ready, usr_q,
        input  cmd_ready, usr_mode, usr_pdata, usr_sin, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data, rsp_ready, usr_q,
        output cmd_ready, usr_mode, usr_pdata, usr_sin, rsp_valid, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/usr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : usr_sequencer
// Brief  : Runs one LOAD/SHR/SHL/READ command on the USR and returns its value.
// Rev    : 1.0  initial release
// ============================================================================
module usr_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic      clk_i,
    input  wire logic      rst_ni,
    usr_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    // Command opcodes share their encoding with the USR mode field.
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= OP_READ;
            fill_q      <= 1'b0;
            data_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fill_d      = fill_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d   = bus.cmd_op;
                    fill_d = bus.cmd_fill;
                    data_d = bus.cmd_data;
                    if (bus.cmd_op == OP_LOAD) begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_RUN;
                    end else if ((bus.cmd_op == OP_SHR || bus.cmd_op == OP_SHL) &&
                                 bus.cmd_count != '0) begin
                        cnt_d   = bus.cmd_count;
                        state_d = S_RUN;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_data_d  = bus.usr_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            default: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    // Outputs decode registers only, so reset forces HOLD without a clock edge.
    always_comb begin
        bus.usr_mode  = (state_q == S_RUN) ? op_q : 2'b00;
        bus.cmd_ready = (state_q == S_IDLE);
        bus.busy      = (state_q != S_IDLE);
        bus.usr_sin   = fill_q;
        bus.usr_pdata = data_q;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_data  = rsp_data_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_usr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_usr_sequencer
// Brief  : Directed self-checking bench for usr_sequencer with a USR model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_usr_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    usr_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

    usr_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // USR model; it has no reset so partial shifts survive a sequencer reset.
    initial bus.usr_q = 8'h00;
    always @(posedge clk) begin
        case (bus.usr_mode)
            2'b01:   bus.usr_q <= {bus.usr_sin, bus.usr_q[7:1]};
            2'b10:   bus.usr_q <= {bus.usr_q[6:0], bus.usr_sin};
            2'b11:   bus.usr_q <= bus.usr_pdata;
            default: bus.usr_q <= bus.usr_q;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command from a negedge; returns data, mode-cycle count and edges to rsp_valid.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic fill,
                          input logic [7:0] data, input bit ack,
                          output logic [7:0] rdata, output int mc, output int lat);
        for (int k = 0; k < 20 && !bus.cmd_ready; k++) @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_count = cnt;
        bus.cmd_fill  = fill;
        bus.cmd_data  = data;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        mc = 0;
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            if (bus.usr_mode != 2'b00) mc++;
            @(posedge clk);
        end
        if (lat >= 40) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: op=%0d no rsp_valid within 40 cycles", op);
        end
        rdata = bus.rsp_data;
        if (ack) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus.rsp_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12 rst_n = 1'b0;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.usr_mode !== 2'b00) begin errors++; $display("FAIL rst_mode: got %b want 00", bus.usr_mode); end
        checks++; if (bus.usr_pdata !== 8'h00) begin errors++; $display("FAIL rst_pdata: got %h want 00", bus.usr_pdata); end
        checks++; if (bus.usr_sin !== 1'b0) begin errors++; $display("FAIL rst_sin: got %b want 0", bus.usr_sin); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data: got %h want 00", bus.rsp_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL release_idle: ready=%b busy=%b want 1/0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_load_read();
        logic [7:0] d; int mc; int lat;
        do_cmd(2'b11, 4'd0, 1'b0, 8'hA5, 1'b1, d, mc, lat);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL load_data: got %h want a5", d); end
        checks++; if (mc != 1) begin errors++; $display("FAIL load_mode_cycles: got %0d want 1", mc); end
        checks++; if (lat != 2) begin errors++; $display("FAIL load_latency: got %0d want 2", lat); end
        do_cmd(2'b00, 4'd5, 1'b1, 8'h00, 1'b1, d, mc, lat);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", d); end
        checks++; if (mc != 0 || lat != 1) begin errors++; $display("FAIL read_timing: mc=%0d lat=%0d want 0/1", mc, lat); end
    endtask

    task automatic test_shift();
        logic [7:0] d; int mc; int lat;
        do_cmd(2'b01, 4'd3, 1'b1, 8'h00, 1'b1, d, mc, lat);
        checks++; if (d !== 8'hF4) begin errors++; $display("FAIL shr3_data: got %h want f4", d); end
        checks++; if (mc != 3 || lat != 4) begin errors++; $display("FAIL shr3_timing: mc=%0d lat=%0d want 3/4", mc, lat); end
        do_cmd(2'b11, 4'd0, 1'b0, 8'hA5, 1'b1, d, mc, lat);
        do_cmd(2'b10, 4'd2, 1'b0, 8'hFF, 1'b1, d, mc, lat);
        checks++; if (d !== 8'h94) begin errors++; $display("FAIL shl2_data: got %h want 94", d); end
        checks++; if (mc != 2 || lat != 3) begin errors++; $display("FAIL shl2_timing: mc=%0d lat=%0d want 2/3", mc, lat); end
    endtask

    task automatic test_boundary();
        logic [7:0] d; int mc; int lat;
        do_cmd(2'b10, 4'd0, 1'b1, 8'h00, 1'b1, d, mc, lat);
        checks++; if (d !== 8'h94) begin errors++; $display("FAIL shl0_data: got %h want 94", d); end
        checks++; if (mc != 0 || lat != 1) begin errors++; $display("FAIL shl0_timing: mc=%0d lat=%0d want 0/1", mc, lat); end
        do_cmd(2'b11, 4'd0, 1'b0, 8'hFF, 1'b1, d, mc, lat);
        do_cmd(2'b01, 4'd15, 1'b0, 8'h00, 1'b1, d, mc, lat);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL shr15_data: got %h want 00", d); end
        checks++; if (mc != 15 || lat != 16) begin errors++; $display("FAIL shr15_timing: mc=%0d lat=%0d want 15/16", mc, lat); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; int mc; int lat;
        do_cmd(2'b11, 4'd0, 1'b0, 8'h5A, 1'b1, d, mc, lat);
        do_cmd(2'b00, 4'd0, 1'b0, 8'h00, 1'b0, d, mc, lat);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A || bus.usr_mode !== 2'b00) begin
                errors++; $display("FAIL backpressure[%0d]: ready=%b valid=%b data=%h mode=%b want 0/1/5a/00",
                                   i, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.usr_mode);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rsp_done: valid=%b ready=%b want 0/1", bus.rsp_valid, bus.cmd_ready);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL next_accept: busy=%b ready=%b want 1/0", bus.busy, bus.cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A) begin
            errors++; $display("FAIL next_rsp: valid=%b data=%h want 1/5a", bus.rsp_valid, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d; int mc; int lat; bit seen_valid;
        do_cmd(2'b11, 4'd0, 1'b0, 8'h3C, 1'b1, d, mc, lat);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_count = 4'd6;
        bus.cmd_fill  = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.usr_mode !== 2'b01) begin errors++; $display("FAIL run_mode: got %b want 01", bus.usr_mode); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.usr_mode !== 2'b00 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL async_rst: mode=%b busy=%b ready=%b want 00/0/1", bus.usr_mode, bus.busy, bus.cmd_ready);
        end
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00) begin
            errors++; $display("FAIL async_rst_rsp: valid=%b data=%h want 0/00", bus.rsp_valid, bus.rsp_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen_valid = 1'b1;
        end
        checks++; if (seen_valid) begin errors++; $display("FAIL no_rsp_after_rst: got rsp_valid=1 want 0"); end
        do_cmd(2'b00, 4'd0, 1'b0, 8'h00, 1'b1, d, mc, lat);
        checks++; if (d !== 8'hE7 || lat != 1) begin errors++; $display("FAIL read_after_rst: data=%h lat=%0d want e7/1", d, lat); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_count = 4'd0;
        bus.cmd_fill  = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_load_read();
        test_shift();
        test_boundary();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
